// File: rtl/led_controller_pkg.sv
// led_controller_pkg: shared constants and types for the LED DMA controller.
//   LED_NUM / LED_MEM / DATA_ADDR_WIDTH / LED_NUM_WIDTH : default geometry
//   led_state_t : controller state encoding (IDLE, READ, DRAIN)
//   idx_width()  : index width that stays >= 1 even for a single LED
package led_controller_pkg;

  localparam int DATA_ADDR_WIDTH = 10;
  localparam int LED_NUM         = 16;
  localparam int LED_MEM         = 'h3F0;

  // $clog2(1) is 0, which would give a zero-width index register.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int LED_NUM_WIDTH = idx_width(LED_NUM);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } led_state_t;

endpackage

// File: rtl/led_controller.sv
// led_controller: memory-to-pins DMA. On copy_start it reads LED_COUNT
// consecutive 16-bit words starting at LED_ADDR, reduces each to one bit
// (nonzero = lit) and commits the whole frame to leds_out in one edge.
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-low
//   copy_start   copy request, sampled only in IDLE
//   mem_din_re   memory read enable (READ only)
//   mem_din_addr memory read address
//   mem_din      read data, valid one cycle after its address
//   busy         high in READ and DRAIN
//   done         one-cycle pulse after the frame is committed
//   leds_out     LED drive; bit LED_COUNT-1-i = word at LED_ADDR+i
module led_controller
  import led_controller_pkg::*;
#(
  parameter int LED_COUNT       = LED_NUM,
  parameter int LED_ADDR        = LED_MEM,
  parameter int ADDR_WIDTH      = DATA_ADDR_WIDTH,
  parameter int LED_COUNT_WIDTH = idx_width(LED_COUNT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  copy_start,
  output logic                  mem_din_re,
  output logic [ADDR_WIDTH-1:0] mem_din_addr,
  input  logic [15:0]           mem_din,
  output logic                  busy,
  output logic                  done,
  output logic [LED_COUNT-1:0]  leds_out
);

  localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(LED_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(LED_ADDR + LED_COUNT - 1);

  led_state_t                 state;
  led_state_t                 state_next;
  logic [ADDR_WIDTH-1:0]      addr;
  logic [ADDR_WIDTH-1:0]      offset;
  logic                       rd_valid;
  logic [LED_COUNT_WIDTH-1:0] rd_idx;
  logic [LED_COUNT-1:0]       shadow;
  logic [LED_COUNT-1:0]       shadow_cap;

  assign mem_din_re   = (state == READ);
  assign busy         = (state == READ) || (state == DRAIN);
  assign mem_din_addr = addr;
  assign offset       = addr - FIRST_ADDR;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (copy_start) state_next = READ;
      READ:    if (addr == LAST_ADDR) state_next = DRAIN;
      DRAIN:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The word addressed on the previous cycle arrives now; fold it into the
  // shadow frame. DRAIN commits this merged value so the last word is not
  // lost to the one-cycle RAM latency.
  always_comb begin
    shadow_cap = shadow;
    for (int i = 0; i < LED_COUNT; i++) begin
      if (rd_valid && (rd_idx == LED_COUNT_WIDTH'(LED_COUNT - 1 - i)))
        shadow_cap[i] = |mem_din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      addr     <= FIRST_ADDR;
      rd_valid <= 1'b0;
      rd_idx   <= '0;
      shadow   <= '0;
      leds_out <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      shadow   <= shadow_cap;
      rd_valid <= (state == READ);
      done     <= (state == DRAIN);
      if (state == READ) begin
        rd_idx <= LED_COUNT_WIDTH'(offset);
        addr   <= (addr == LAST_ADDR) ? FIRST_ADDR : addr + ADDR_WIDTH'(1);
      end
      // Single commit point: pins never show a partially copied frame.
      if (state == DRAIN)
        leds_out <= shadow_cap;
    end
  end

endmodule

// File: tb/tb_led_controller.sv
// tb_led_controller: randomized scoreboard bench for led_controller.
// A transaction-level model decides which copy requests are accepted,
// pushes the expected frame from a memory snapshot, and predicts the
// busy/read/address/done timeline; a negedge monitor pops and compares.
module tb_led_controller;

  localparam int LC = 4;
  localparam int AW = 8;
  localparam int LA = 'h20;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          copy_start;
  logic          mem_din_re;
  logic [AW-1:0] mem_din_addr;
  logic [15:0]   mem_din;
  logic          busy;
  logic          done;
  logic [LC-1:0] leds_out;

  logic          copy_start1;
  logic          re1;
  logic [AW-1:0] addr1;
  logic [15:0]   din1;
  logic          busy1;
  logic          done1;
  logic [0:0]    leds1;

  logic [15:0] mem  [0:255];
  logic [15:0] mem1 [0:255];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  led_controller #(.LED_COUNT(LC), .LED_ADDR(LA), .ADDR_WIDTH(AW), .LED_COUNT_WIDTH(IW)) u_dut (
    .clk(clk), .reset(reset), .copy_start(copy_start), .mem_din_re(mem_din_re),
    .mem_din_addr(mem_din_addr), .mem_din(mem_din), .busy(busy), .done(done),
    .leds_out(leds_out)
  );

  led_controller #(.LED_COUNT(1), .LED_ADDR(LA), .ADDR_WIDTH(AW), .LED_COUNT_WIDTH(1)) u_dut1 (
    .clk(clk), .reset(reset), .copy_start(copy_start1), .mem_din_re(re1),
    .mem_din_addr(addr1), .mem_din(din1), .busy(busy1), .done(done1),
    .leds_out(leds1)
  );

  // Synchronous RAMs with one-cycle read latency.
  always @(posedge clk) begin
    mem_din <= mem[mem_din_addr];
    din1    <= mem1[addr1];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [LC-1:0] frame_of_mem();
    logic [LC-1:0] f;
    for (int i = 0; i < LC; i++) f[LC-1-i] = (mem[LA+i] != 16'h0);
    return f;
  endfunction

  // Transaction model: a transfer occupies LC+1 busy cycles; the first
  // LC of them present addresses LA..LA+LC-1, then done follows.
  int            cnt;
  bit            done_m;
  logic [LC-1:0] exp_q[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    = 0;
      done_m = 0;
      exp_q.delete();
    end else begin
      done_m = 0;
      if (cnt > 0) begin
        if (cnt == 1) done_m = 1;
        cnt--;
      end else if (copy_start) begin
        exp_q.push_back(frame_of_mem());
        cnt = LC + 1;
      end
    end
  end

  bit            running = 0;
  int            done_seen = 0;
  logic [LC-1:0] last_leds = '0;

  always @(negedge clk) begin
    if (!reset) begin
      last_leds = '0;
    end else if (running) begin
      chk("busy", 32'(busy), 32'(cnt > 0));
      chk("mem_din_re", 32'(mem_din_re), 32'(cnt >= 2));
      chk("mem_din_addr", 32'(mem_din_addr),
          (cnt >= 2) ? 32'(LA + LC + 1 - cnt) : 32'(LA));
      chk("done", 32'(done), 32'(done_m));
      if (done) begin
        done_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'(0));
        end else begin
          chk("leds_frame", 32'(leds_out), 32'(exp_q.pop_front()));
        end
        last_leds = leds_out;
      end else begin
        chk("leds_stable", 32'(leds_out), 32'(last_leds));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int d0;
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 16'h0;
      mem1[i] = 16'h0;
    end
    reset       = 1'b0;
    copy_start  = 1'b0;
    copy_start1 = 1'b0;
    cycles(3);
    chk("reset_leds", 32'(leds_out), 32'(0));
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_addr", 32'(mem_din_addr), 32'(LA));
    chk("reset_done", 32'(done), 32'(0));
    reset = 1'b1;
    cycles(1);

    // Single-LED instance: READ one cycle, DRAIN one cycle, commit after E2.
    mem1[LA]    = 16'h8000;
    copy_start1 = 1'b1;
    cycles(1);
    copy_start1 = 1'b0;
    chk("one_read_busy", 32'(busy1), 32'(1));
    chk("one_read_re", 32'(re1), 32'(1));
    chk("one_read_addr", 32'(addr1), 32'(LA));
    cycles(1);
    chk("one_drain_re", 32'(re1), 32'(0));
    chk("one_drain_busy", 32'(busy1), 32'(1));
    chk("one_drain_leds", 32'(leds1), 32'(0));
    cycles(1);
    chk("one_done", 32'(done1), 32'(1));
    chk("one_leds", 32'(leds1), 32'(1));
    chk("one_idle", 32'(busy1), 32'(0));
    cycles(1);
    chk("one_done_clear", 32'(done1), 32'(0));

    running = 1;

    // Basic copy.
    mem[LA] = 16'hFFFF; mem[LA+1] = 16'h0; mem[LA+2] = 16'h0; mem[LA+3] = 16'h0001;
    copy_start = 1'b1;
    cycles(1);
    copy_start = 1'b0;
    cycles(8);
    chk("basic_leds", 32'(leds_out), 32'('b1001));

    // Atomicity: monitor enforces stability until the commit edge.
    mem[LA] = 16'h0; mem[LA+1] = 16'hFFFF; mem[LA+2] = 16'hFFFF; mem[LA+3] = 16'h0;
    copy_start = 1'b1;
    cycles(1);
    copy_start = 1'b0;
    cycles(3);
    chk("atomic_mid", 32'(leds_out), 32'('b1001));
    cycles(5);
    chk("atomic_leds", 32'(leds_out), 32'('b0110));

    // Request during READ is ignored.
    d0 = done_seen;
    copy_start = 1'b1;
    cycles(1);
    copy_start = 1'b0;
    cycles(1);
    copy_start = 1'b1;
    cycles(1);
    copy_start = 1'b0;
    cycles(10);
    chk("ignore_done_count", 32'(done_seen - d0), 32'(1));
    chk("ignore_idle", 32'(busy), 32'(0));

    // Held request: back-to-back transfers every LC+2 cycles.
    d0 = done_seen;
    mem[LA+3] = 16'h0100;
    copy_start = 1'b1;
    cycles(20);
    copy_start = 1'b0;
    cycles(10);
    chk("held_done_count", 32'(done_seen - d0), 32'(4));

    // Asynchronous reset during the third READ cycle.
    copy_start = 1'b1;
    cycles(1);
    copy_start = 1'b0;
    cycles(2);
    #2 reset = 1'b0;
    #1;
    chk("rst_leds", 32'(leds_out), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_re", 32'(mem_din_re), 32'(0));
    chk("rst_addr", 32'(mem_din_addr), 32'(LA));
    cycles(1);
    #2 reset = 1'b1;
    cycles(1);
    mem[LA] = 16'h0; mem[LA+1] = 16'h0; mem[LA+2] = 16'h0040; mem[LA+3] = 16'h0;
    copy_start = 1'b1;
    cycles(1);
    copy_start = 1'b0;
    cycles(8);
    chk("after_rst_leds", 32'(leds_out), 32'('b0010));

    // Randomized traffic; memory only rewritten while no transfer is active.
    for (int c = 0; c < 400; c++) begin
      if (cnt == 0 && $urandom_range(2) == 0) begin
        for (int i = 0; i < LC; i++)
          mem[LA+i] = ($urandom_range(1) == 0) ? 16'h0 : 16'(1 << $urandom_range(15));
      end
      copy_start = ($urandom_range(2) == 0);
      cycles(1);
    end
    copy_start = 1'b0;
    cycles(10);
    running = 0;
    chk("queue_empty", 32'(exp_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
